// File: rtl/exp_operand_loader_if.sv
// Host-side word streams of the exponentiation operand loader: operand words in, result words out.
// Latency: none, this is only a bundle of wires.
// Backpressure: valid/ready on both streams; a word moves when valid and ready are high at the same edge.
interface exp_operand_loader_if #(
    parameter int WORD_W = 32
);
    // operand words flowing host -> loader
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    // result words flowing loader -> host
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    // host / DMA side
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // loader side
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/exp_operand_loader.sv
// Loads five OP_W operands from a word stream, kicks the exp core, and streams its result back out.
// Latency: exp_start one cycle after the last input word; first result word one cycle after exp_done.
// Backpressure: s_ready only in LOAD; m_data/m_last hold while m_ready is low. Watchdog: LOADER_TIMEOUT_EN.
module exp_operand_loader #(
    parameter int WORD_W         = 32,
    parameter int OP_W           = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_start,
    input  logic                cmd_mul,
    output logic                busy,
    exp_operand_loader_if.slave bus,
    output logic [OP_W-1:0]     modulus,
    output logic [OP_W-1:0]     rmodm,
    output logic [OP_W-1:0]     rsquaredmodm,
    output logic [OP_W-1:0]     exponent,
    output logic [OP_W-1:0]     x,
    output logic                exp_start,
    output logic                exp_mul_en,
    input  logic                exp_done,
    input  logic [OP_W-1:0]     exp_result,
    output logic                err
);
    localparam int WORDS = OP_W / WORD_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    // operand slots in stream order; multiplication jumps from RSQ straight to X
    localparam logic [2:0] OP_MOD   = 3'd0;
    localparam logic [2:0] OP_RMODM = 3'd1;
    localparam logic [2:0] OP_RSQ   = 3'd2;
    localparam logic [2:0] OP_EXP   = 3'd3;
    localparam logic [2:0] OP_X     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [2:0]       op_idx;
    logic [OP_W-1:0]  res;
    logic             s_ready_q;
    logic             m_valid_q;
    logic             m_last_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // counts cycles since the start pulse; reaching TIMEOUT_CYCLES abandons the job
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_data  = res[WORD_W-1:0];

    // job sequencer: operand assembly, core start, result capture and drain, all outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            out_cnt      <= '0;
            op_idx       <= '0;
            res          <= '0;
            modulus      <= '0;
            rmodm        <= '0;
            rsquaredmodm <= '0;
            exponent     <= '0;
            x            <= '0;
            exp_start    <= 1'b0;
            exp_mul_en   <= 1'b0;
            busy         <= 1'b0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_cnt      <= '0;
            err          <= 1'b0;
`endif
        end else begin
            exp_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        exp_mul_en <= cmd_mul;
                        word_cnt   <= '0;
                        op_idx     <= OP_MOD;
                        busy       <= 1'b1;
                        s_ready_q  <= 1'b1;
                        state      <= S_LOAD;
`ifdef LOADER_TIMEOUT_EN
                        err        <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (bus.s_valid) begin
                        // words arrive LSW first, so each one enters at the top and slides down
                        case (op_idx)
                            OP_MOD:   modulus      <= {bus.s_data, modulus[OP_W-1:WORD_W]};
                            OP_RMODM: rmodm        <= {bus.s_data, rmodm[OP_W-1:WORD_W]};
                            OP_RSQ:   rsquaredmodm <= {bus.s_data, rsquaredmodm[OP_W-1:WORD_W]};
                            OP_EXP:   exponent     <= {bus.s_data, exponent[OP_W-1:WORD_W]};
                            OP_X:     x            <= {bus.s_data, x[OP_W-1:WORD_W]};
                            default:  ;
                        endcase
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            if (op_idx == OP_X) begin
                                s_ready_q <= 1'b0;
                                exp_start <= 1'b1;
                                state     <= S_START;
`ifdef LOADER_TIMEOUT_EN
                                tmo_cnt   <= '0;
`endif
                            end else if (exp_mul_en && op_idx == OP_RSQ) begin
                                op_idx <= OP_X;
                            end else begin
                                op_idx <= op_idx + 3'd1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
`ifdef LOADER_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                S_WAIT: begin
                    if (exp_done) begin
                        res       <= exp_result;
                        out_cnt   <= '0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        state     <= S_DRAIN;
`ifdef LOADER_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    if (bus.m_ready) begin
                        res <= {{WORD_W{1'b0}}, res[OP_W-1:WORD_W]};
                        if (out_cnt == LAST_WORD) begin
                            out_cnt   <= '0;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            out_cnt  <= out_cnt + 1'b1;
                            m_last_q <= (out_cnt == LAST_WORD - 1'b1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_operand_loader.sv
// Randomised bench for exp_operand_loader with a stub core (done 20 cycles after the start pulse).
// Operand and result expectations come from word arrays assembled with plain arithmetic.
// Builds with or without LOADER_TIMEOUT_EN; the watchdog job checks whichever behaviour is compiled.
module tb_exp_operand_loader;
    localparam int WORD_W = 32;
    localparam int OP_W   = 512;
    localparam int WORDS  = OP_W / WORD_W;
    localparam int TMO    = 100;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            cmd_start = 1'b0;
    logic            cmd_mul = 1'b0;
    logic            busy;
    logic            exp_start;
    logic            exp_mul_en;
    logic            exp_done = 1'b0;
    logic            err;
    logic [OP_W-1:0] modulus, rmodm, rsquaredmodm, exponent, x;
    logic [OP_W-1:0] stub_result = '0;

    exp_operand_loader_if #(.WORD_W(WORD_W)) bus ();

    exp_operand_loader #(
        .WORD_W(WORD_W),
        .OP_W(OP_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cmd_start(cmd_start),
        .cmd_mul(cmd_mul),
        .busy(busy),
        .bus(bus),
        .modulus(modulus),
        .rmodm(rmodm),
        .rsquaredmodm(rsquaredmodm),
        .exponent(exponent),
        .x(x),
        .exp_start(exp_start),
        .exp_mul_en(exp_mul_en),
        .exp_done(exp_done),
        .exp_result(stub_result),
        .err(err)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad = 0;
    logic [31:0]     wdat [5*WORDS];
    logic [OP_W-1:0] exp_model = '0;
    bit              stub_en = 1'b1;
    int              stub_cnt = 0;
    int              start_pulses = 0;

    // stub core: independent of resetn so a job aborted by reset still sees its late done
    always @(posedge clk) begin
        exp_done <= 1'b0;
        if (exp_start) start_pulses <= start_pulses + 1;
        if (exp_start && stub_en) begin
            stub_cnt <= 20;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) exp_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // operand held in stream slot 'slot': WORDS consecutive words, first one least significant
    function automatic logic [OP_W-1:0] slot_val(input int slot);
        logic [OP_W-1:0] v = '0;
        for (int j = 0; j < WORDS; j++) v[j*WORD_W +: WORD_W] = wdat[slot*WORDS + j];
        return v;
    endfunction

    task automatic start_job(input bit mul);
        cmd_start = 1'b1;
        cmd_mul   = mul;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_mul   = 1'b0;
        chk("busy_after_cmd", busy, 1);
        chk("s_ready_in_load", bus.s_ready, 1);
        chk("mul_en_latched", exp_mul_en, mul);
        chk("err_cleared", err, 0);
    endtask

    task automatic load_words(input bit mul, input bit noisy);
        int n = mul ? 4*WORDS : 5*WORDS;
        int k = 0;
        int guard = 0;
        int pulses0 = start_pulses;
        bit hs;
        while (k < n && guard < 4000) begin
            bus.s_valid = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_data  = wdat[k];
            cmd_start   = noisy && ($urandom_range(0, 7) == 0);
            cmd_mul     = noisy && ($urandom_range(0, 1) == 1);
            hs = bus.s_valid && bus.s_ready;
            @(negedge clk);
            guard++;
            if (hs) k++;
        end
        bus.s_valid = 1'b0;
        cmd_start   = 1'b0;
        cmd_mul     = 1'b0;
        chk("words_accepted", k, n);
        chk("start_pulse_on", exp_start, 1);
        chk("s_ready_off", bus.s_ready, 0);
        @(negedge clk);
        chk("start_pulse_off", exp_start, 0);
        chk("start_pulse_count", start_pulses - pulses0, 1);
        chk("mul_en_held", exp_mul_en, mul);
        chk("modulus", modulus, slot_val(0));
        chk("rmodm", rmodm, slot_val(1));
        chk("rsquaredmodm", rsquaredmodm, slot_val(2));
        if (mul) begin
            chk("x", x, slot_val(3));
            chk("exponent_kept", exponent, exp_model);
        end else begin
            chk("exponent", exponent, slot_val(3));
            chk("x", x, slot_val(4));
            exp_model = slot_val(3);
        end
    endtask

    // mode 0: m_ready always high, 1: alternating 1,0,1,0..., 2: random
    task automatic drain(input int mode, input bit poke);
        int guard = 0;
        int beat = 0;
        int cyc = 0;
        bit hs;
        while (!exp_done && guard < 200) begin
            cmd_start = poke && (guard == 5);
            @(negedge clk);
            guard++;
        end
        cmd_start = 1'b0;
        chk("done_seen", exp_done, 1);
        chk("m_valid_before_done", bus.m_valid, 0);
        @(negedge clk);
        chk("m_valid_rise", bus.m_valid, 1);
        chk("busy_in_drain", busy, 1);
        guard = 0;
        while (beat < WORDS && guard < 400) begin
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (cyc % 2 == 0);
                default: bus.m_ready = ($urandom_range(0, 1) == 1);
            endcase
            cyc++;
            chk("m_data", bus.m_data, stub_result[beat*WORD_W +: WORD_W]);
            chk("m_last", bus.m_last, beat == WORDS - 1);
            hs = bus.m_valid && bus.m_ready;
            @(negedge clk);
            guard++;
            if (hs) beat++;
        end
        bus.m_ready = 1'b0;
        chk("beats", beat, WORDS);
        chk("busy_end", busy, 0);
        chk("m_valid_end", bus.m_valid, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_m_valid"}, bus.m_valid, 0);
        chk({tag, "_m_data"}, bus.m_data, 0);
        chk({tag, "_m_last"}, bus.m_last, 0);
        chk({tag, "_modulus"}, modulus, 0);
        chk({tag, "_rmodm"}, rmodm, 0);
        chk({tag, "_rsq"}, rsquaredmodm, 0);
        chk({tag, "_exponent"}, exponent, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_exp_start"}, exp_start, 0);
        chk({tag, "_mul_en"}, exp_mul_en, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic fill_count();
        for (int k = 0; k < 5*WORDS; k++) wdat[k] = k;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 5*WORDS; k++) wdat[k] = $urandom;
    endtask

    task automatic random_result();
        for (int j = 0; j < WORDS; j++) stub_result[j*WORD_W +: WORD_W] = $urandom;
    endtask

    initial begin
        int c;
        int seen_valid;
        int seen_done;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", busy, 0);

        // counting words, exponentiation, fixed result pattern, alternating m_ready
        fill_count();
        for (int j = 0; j < WORDS; j++) stub_result[j*WORD_W +: WORD_W] = 32'hA000_0000 + j;
        start_job(1'b0);
        load_words(1'b0, 1'b0);
        chk("modulus_w5", modulus[5*WORD_W +: WORD_W], 5);
        chk("x_lsw", x[WORD_W-1:0], 64);
        drain(1, 1'b0);

        // random operands with exponent forced to 7, random m_ready
        fill_random();
        wdat[3*WORDS] = 32'd7;
        for (int j = 1; j < WORDS; j++) wdat[3*WORDS + j] = '0;
        random_result();
        start_job(1'b0);
        load_words(1'b0, 1'b0);
        drain(2, 1'b0);

        // multiplication: exponent slot skipped, register keeps 7
        fill_count();
        random_result();
        start_job(1'b1);
        load_words(1'b1, 1'b0);
        chk("exponent_still_7", exponent, 7);
        chk("x_lsw_mul", x[WORD_W-1:0], 48);
        drain(0, 1'b0);

        // input gaps plus stray commands in LOAD and WAIT
        fill_count();
        random_result();
        start_job(1'b0);
        load_words(1'b0, 1'b1);
        chk("noisy_x_lsw", x[WORD_W-1:0], 64);
        drain(2, 1'b1);

        // reset while waiting on the core; its later done must be ignored
        fill_random();
        random_result();
        start_job(1'b0);
        load_words(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_idle_zero("abort");
        resetn = 1'b1;
        exp_model = '0;
        seen_valid = 0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen_valid++;
            if (exp_done) seen_done++;
        end
        chk("late_done_happened", seen_done > 0, 1);
        chk("late_done_no_output", seen_valid, 0);
        chk("late_done_busy", busy, 0);

        // core that never answers
        stub_en = 1'b0;
        fill_random();
        start_job(1'b0);
        load_words(1'b0, 1'b0);
`ifdef LOADER_TIMEOUT_EN
        c = 1;
        while (busy && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_cycles", c, TMO);
        chk("timeout_err", err, 1);
        chk("timeout_no_output", bus.m_valid, 0);
        start_job(1'b0);
`else
        seen_valid = 0;
        c = 0;
        for (int i = 0; i < 3*TMO; i++) begin
            @(negedge clk);
            if (!busy) c++;
            if (bus.m_valid) seen_valid++;
        end
        chk("no_watchdog_idle_cycles", c, 0);
        chk("no_watchdog_err", err, 0);
        chk("no_watchdog_output", seen_valid, 0);
`endif
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
